// File: rtl/program_feeder.sv
// ---------------------------------------------------------------------------
// program_feeder
//   Upstream instruction sequencer for a multicycle processor. Reads 16-bit
//   words from a synchronous program memory and presents each instruction on
//   DIN with a one-cycle run pulse. Between instructions it waits for done.
//   Move-immediate instructions (opcode word[9:6] == IMM_OPC) are followed by
//   their immediate word, which replaces the instruction on DIN while the
//   processor executes. Execution stops after the instruction at the
//   address latched from endAddr when start is accepted.
//
// Optional feature: define FEEDER_WATCHDOG_EN to add a done-wait watchdog.
//   The watchdog halts the feeder and raises a sticky timeout flag when
//   TIMEOUT cycles pass in EXEC without done. Without the macro there is no
//   counter, timeout is always 0 and EXEC waits for done indefinitely.
//
// Ports
//   clock    in   1       rising-edge clock
//   reset    in   1       asynchronous active-high reset
//   start    in   1       begin execution at address 0 (IDLE/HALT only)
//   endAddr  in   ADDR_W  address of the last instruction word
//   memAddr  out  ADDR_W  program memory read address
//   memRd    out  1       read strobe; memData valid on the following cycle
//   memData  in   16      program memory read data
//   DIN      out  16      instruction / immediate word to the processor
//   run      out  1       processor latches DIN as a new instruction
//   done     in   1       processor instruction-complete flag
//   busy     out  1       execution in progress
//   halted   out  1       program finished (or watchdog fired)
//   timeout  out  1       sticky watchdog error
//
// State   | meaning
// IDLE    | after reset, waiting for start
// FETCH   | read strobe for the instruction at pc
// LOAD    | instruction word arrives, latched into DIN
// ISSUE   | run pulse; immediate word requested if needed
// IMM     | immediate word arrives, replaces DIN
// EXEC    | waiting for done
// HALT    | program complete, waiting for start
// ---------------------------------------------------------------------------
module program_feeder #(
  parameter int          ADDR_W  = 8,
  parameter logic [3:0]  IMM_OPC = 4'b0001,
  parameter int          TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] endAddr,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic [15:0]       memData,
  output logic [15:0]       DIN,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   cur_pc_q, cur_pc_d;
  logic [ADDR_W-1:0]   end_latch_q, end_latch_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [15:0]         din_q, din_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;

`ifdef FEEDER_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cur_pc_d    = cur_pc_q;
    end_latch_d = end_latch_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    din_d       = din_q;
    run_d       = 1'b0;
    timeout_d   = timeout_q;
`ifdef FEEDER_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d        = '0;
          end_latch_d = endAddr;
          mem_addr_d  = '0;
          mem_rd_d    = 1'b1;
          timeout_d   = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        // The instruction word is on memData now, so the immediate read for
        // ISSUE can be decided here and registered alongside run.
        din_d    = memData;
        cur_pc_d = pc_q;
        pc_d     = pc_q + ADDR_W'(1);
        run_d    = 1'b1;
        if (memData[9:6] == IMM_OPC) begin
          mem_addr_d = pc_q + ADDR_W'(1);
          mem_rd_d   = 1'b1;
        end
        state_d  = S_ISSUE;
      end

      S_ISSUE: begin
`ifdef FEEDER_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        if (din_q[9:6] == IMM_OPC) state_d = S_IMM;
        else                       state_d = S_EXEC;
      end

      S_IMM: begin
        din_d   = memData;
        pc_d    = pc_q + ADDR_W'(1);
`ifdef FEEDER_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (done) begin
          // Only the instruction address is compared; an immediate word at
          // end_latch does not end the program.
          if (cur_pc_q == end_latch_q) begin
            state_d = S_HALT;
          end else begin
            mem_addr_d = pc_q;
            mem_rd_d   = 1'b1;
            state_d    = S_FETCH;
          end
        end
`ifdef FEEDER_WATCHDOG_EN
        else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase

`ifndef FEEDER_WATCHDOG_EN
    timeout_d = 1'b0;
`endif

    busy_d   = (state_d == S_FETCH) || (state_d == S_LOAD) ||
               (state_d == S_ISSUE) || (state_d == S_IMM)  ||
               (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cur_pc_q    <= '0;
      end_latch_q <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      din_q       <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef FEEDER_WATCHDOG_EN
      wd_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cur_pc_q    <= cur_pc_d;
      end_latch_q <= end_latch_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      din_q       <= din_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
`ifdef FEEDER_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
`endif
    end
  end

  assign memAddr = mem_addr_q;
  assign memRd   = mem_rd_q;
  assign DIN     = din_q;
  assign run     = run_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_program_feeder.sv
module tb_program_feeder;
  localparam int         AW  = 8;
  localparam logic [3:0] OPC = 4'b0001;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          done  = 1'b0;
  logic [AW-1:0] endAddr = '0;
  logic [AW-1:0] memAddr;
  logic          memRd, run, busy, halted, timeout;
  logic [15:0]   memData = '0;
  logic [15:0]   DIN;
  logic [15:0]   mem [256];

  int checks   = 0;
  int failures = 0;

  program_feeder #(.ADDR_W(AW), .IMM_OPC(OPC), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start), .endAddr(endAddr),
    .memAddr(memAddr), .memRd(memRd), .memData(memData), .DIN(DIN),
    .run(run), .done(done), .busy(busy), .halted(halted), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // synchronous program memory
  always @(posedge clock) if (memRd) memData <= mem[memAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_word(input bit im);
    logic [15:0] w;
    w = 16'($urandom);
    if (im) w[9:6] = OPC;
    else if (w[9:6] == OPC) w[9:6] = 4'b1010;
    return w;
  endfunction

  // straight-line program from address 0 up to end_a (no wrap)
  task automatic gen_prog(input int end_a, input int pct);
    int a;
    bit im;
    a = 0;
    for (int n = 0; n < 300; n++) begin
      im = ($urandom_range(99) < pct) && (a + 1 != end_a);
      mem[a] = rand_word(im);
      if (a == end_a) begin
        if (im) mem[a+1] = 16'($urandom);
        break;
      end
      if (im) begin mem[a+1] = 16'($urandom); a += 2; end
      else a += 1;
    end
  endtask

  // Reference: walk memory as the processor would see it, then follow the
  // DUT cycle by cycle with a processor that answers done after a delay.
  task automatic run_prog(input int end_a, input int dmin, input int dmax,
                          input bit early, input bit spurious);
    logic [15:0] qw[$];
    logic [15:0] qi[$];
    bit          qf[$];
    int          qa[$];
    logic [15:0] w;
    int pc, cur, idx, cyc, run_cyc, done_at, exp_run, k, budget, exec0;
    bit fin;
    pc = 0;
    for (int n = 0; n < 1000; n++) begin
      w = mem[pc]; cur = pc; pc = (pc + 1) % 256;
      qw.push_back(w); qa.push_back(cur);
      qf.push_back(w[9:6] == OPC);
      if (w[9:6] == OPC) begin qi.push_back(mem[pc]); pc = (pc + 1) % 256; end
      else qi.push_back(w);
      if (cur == end_a) break;
    end
    budget = qw.size() * (dmax + 8) + 20;

    @(negedge clock); start = 1'b1; endAddr = AW'(end_a);
    @(negedge clock); start = 1'b0; endAddr = AW'($urandom);
    chk("start_busy", busy, 1); chk("start_halted", halted, 0);
    chk("start_memrd", memRd, 1); chk("start_memaddr", memAddr, 0);
    chk("start_timeout", timeout, 0);

    idx = 0; cyc = 0; run_cyc = -1; done_at = -1; exp_run = 2; fin = 0;
    while (!fin && cyc < budget) begin
      @(negedge clock); cyc++;
      done = 1'b0; start = 1'b0;
      if (run) begin
        if (idx >= qw.size()) begin
          chk("extra_run", 1, 0);
          fin = 1;
        end else begin
          chk("run_time", cyc, exp_run);
          chk("run_din", DIN, qw[idx]);
          run_cyc = cyc;
          k = dmin + $urandom_range(dmax - dmin);
          if (k < (qf[idx] ? 2 : 1)) k = qf[idx] ? 2 : 1;
          done_at = cyc + k;
          exp_run = done_at + 3;
          if (early) done = 1'b1;
          if (spurious && idx == 1) begin start = 1'b1; endAddr = '0; end
        end
      end else if (run_cyc >= 0 && cyc > run_cyc && cyc <= done_at) begin
        exec0 = run_cyc + (qf[idx] ? 2 : 1);
        if (cyc < exec0) begin
          if (early) done = 1'b1;
        end else begin
          chk("exec_din", DIN, qi[idx]);
          chk("exec_memrd", memRd, 0);
          chk("exec_busy", busy, 1);
          if (cyc == done_at) done = 1'b1;
        end
      end else if (run_cyc >= 0 && cyc == done_at + 1) begin
        chk("post_timeout", timeout, 0);
        if (idx == qw.size() - 1) begin
          chk("end_halted", halted, 1);
          chk("end_busy", busy, 0);
          fin = 1;
        end else begin
          chk("next_memrd", memRd, 1);
          chk("next_memaddr", memAddr, qa[idx+1]);
          idx++;
        end
      end
    end
    done = 1'b0;
    chk("prog_complete", fin, 1);
    chk("prog_count", idx + 1, qw.size());
  endtask

  initial begin : main
    int seen, k;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    chk("rst_run", run, 0); chk("rst_memrd", memRd, 0);
    chk("rst_din", DIN, 0); chk("rst_memaddr", memAddr, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // reset in the middle of EXEC
    gen_prog(6, 0);
    @(negedge clock); start = 1'b1; endAddr = 8'd6;
    @(negedge clock); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock); if (run) seen = 1;
    end
    chk("rst_mid_run_seen", seen, 1);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_run", run, 0); chk("rstmid_busy", busy, 0);
    chk("rstmid_din", DIN, 0); chk("rstmid_memrd", memRd, 0);
    reset = 1'b0; done = 1'b1;
    @(negedge clock); done = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); if (memRd || run || busy) seen = 1;
    end
    chk("rstmid_quiet", seen, 0);

    // two plain instructions, done three cycles after each run
    mem[0] = 16'h0011; mem[1] = 16'h0022;
    run_prog(1, 3, 3, 0, 0);

    // immediate instruction followed by a plain one
    mem[0] = 16'h0040; mem[1] = 16'h1234; mem[2] = 16'h0005;
    run_prog(2, 1, 3, 0, 0);

    // done during ISSUE/IMM must be ignored
    gen_prog(12, 40);
    run_prog(12, 2, 4, 1, 0);

    // restart from HALT; start while busy ignored
    run_prog(12, 1, 3, 0, 1);

    // endAddr = 0 executes one instruction (plain, then immediate at end)
    mem[0] = rand_word(0);
    run_prog(0, 1, 2, 0, 0);
    mem[0] = rand_word(1); mem[1] = 16'($urandom);
    run_prog(0, 2, 2, 0, 0);

    // randomized programs
    for (int t = 0; t < 6; t++) begin
      k = $urandom_range(40);
      gen_prog(k, 35);
      run_prog(k, 1, 5, t[0], t[1]);
    end

    // pc wrap: immediate at 255 consumes address 0, second pass ends at 1
    for (int i = 2; i < 255; i++) mem[i] = rand_word(0);
    mem[0] = rand_word(1); mem[1] = rand_word(0); mem[255] = rand_word(1);
    run_prog(1, 1, 1, 0, 0);

`ifdef FEEDER_WATCHDOG_EN
    mem[0] = rand_word(0);
    @(negedge clock); start = 1'b1; endAddr = '0;
    @(negedge clock); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock); if (run) seen = 1;
    end
    chk("wd_run_seen", seen, 1);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clock); if (halted) k = i;
    end
    chk("wd_halt_cycle", k, 9);
    chk("wd_timeout", timeout, 1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("wd_cleared", timeout, 0);
    chk("wd_restart_busy", busy, 1);
    repeat (2) @(negedge clock);
    done = 1'b1;
    @(negedge clock); done = 1'b0;
    @(negedge clock);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
